// File: rtl/sha256_sequencer.sv
// sha256_sequencer: drives the SHA_256 core through INIT/LOAD/EXPAND/ROUND/FINAL phases.
// Define SHA_SEQ_DOUBLE_EN to chain a second pass (double SHA-256).
module sha256_sequencer (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] chunk_in,
  input  logic         chunk_last,
  input  logic         chunk_valid,
  output logic         chunk_ready,
  output logic [2:0]   sha_state,
  output logic         sha_flag,
  output logic [511:0] sha_chunk,
  input  logic [255:0] sha_hash,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_REQ,
    S_LOAD,
    S_EXPAND,
    S_ROUND,
    S_FINAL,
    S_CAPTURE
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           last_q, last_d;
  logic [511:0]   chunk_q, chunk_d;
  logic [255:0]   digest_q, digest_d;
  logic           dv_q, dv_d;
  logic [2:0]     code_q, code_d;
  logic           flag_q, flag_d;
`ifdef SHA_SEQ_DOUBLE_EN
  logic           pass_q, pass_d;
`endif

  // Next-state, phase counter and datapath register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    chunk_d  = chunk_q;
    digest_d = digest_q;
    dv_d     = 1'b0;
`ifdef SHA_SEQ_DOUBLE_EN
    pass_d   = pass_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
`ifdef SHA_SEQ_DOUBLE_EN
        if (pass_q) state_d = S_LOAD;
        else        state_d = S_REQ;
`else
        state_d = S_REQ;
`endif
      end
      S_REQ: begin
        if (chunk_valid) begin
          chunk_d = chunk_in;
          last_d  = chunk_last;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = 6'd0;
        state_d = S_EXPAND;
      end
      S_EXPAND: begin
        if (cnt_q == 6'd47) begin
          cnt_d   = 6'd0;
          state_d = S_ROUND;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_ROUND: begin
        if (cnt_q == 6'd63) begin
          cnt_d   = 6'd0;
          state_d = last_q ? S_FINAL : S_REQ;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_FINAL: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
`ifdef SHA_SEQ_DOUBLE_EN
        if (!pass_q) begin
          chunk_d = {sha_hash, 1'b1, 191'b0, 64'd256};
          last_d  = 1'b1;
          pass_d  = 1'b1;
          state_d = S_INIT;
        end else begin
          digest_d = sha_hash;
          dv_d     = 1'b1;
          pass_d   = 1'b0;
          state_d  = S_IDLE;
        end
`else
        digest_d = sha_hash;
        dv_d     = 1'b1;
        state_d  = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Core state/flag codes for the upcoming state, so they register with it
  always_comb begin
    code_d = 3'd0;
    flag_d = 1'b0;
    case (state_d)
      S_IDLE:    code_d = 3'd0;
      S_INIT:    code_d = 3'd1;
      S_REQ:     code_d = 3'd2;
      S_LOAD:    code_d = 3'd3;
      S_EXPAND: begin
        code_d = 3'd3;
        flag_d = 1'b1;
      end
      S_ROUND:   code_d = 3'd4;
      S_FINAL:   code_d = 3'd5;
      S_CAPTURE: code_d = 3'd6;
      default:   code_d = 3'd0;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      last_q   <= 1'b0;
      chunk_q  <= '0;
      digest_q <= '0;
      dv_q     <= 1'b0;
      code_q   <= 3'd0;
      flag_q   <= 1'b0;
`ifdef SHA_SEQ_DOUBLE_EN
      pass_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      chunk_q  <= chunk_d;
      digest_q <= digest_d;
      dv_q     <= dv_d;
      code_q   <= code_d;
      flag_q   <= flag_d;
`ifdef SHA_SEQ_DOUBLE_EN
      pass_q   <= pass_d;
`endif
    end
  end

  assign chunk_ready  = (state_q == S_REQ);
  assign busy         = (state_q != S_IDLE);
  assign sha_state    = code_q;
  assign sha_flag     = flag_q;
  assign sha_chunk    = chunk_q;
  assign digest       = digest_q;
  assign digest_valid = dv_q;

endmodule

// File: tb/tb_sha256_sequencer.sv
// tb_sha256_sequencer: directed bench with a behavioural SHA-256 core model.
// Define SHA_SEQ_DOUBLE_EN to exercise the double-hash build.
module tb_sha256_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [511:0] chunk_in;
  logic         chunk_last;
  logic         chunk_valid;
  logic         chunk_ready;
  logic [2:0]   sha_state;
  logic         sha_flag;
  logic [511:0] sha_chunk;
  logic [255:0] sha_hash = '0;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;

  sha256_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .chunk_in     (chunk_in),
    .chunk_last   (chunk_last),
    .chunk_valid  (chunk_valid),
    .chunk_ready  (chunk_ready),
    .sha_state    (sha_state),
    .sha_flag     (sha_flag),
    .sha_chunk    (sha_chunk),
    .sha_hash     (sha_hash),
    .digest       (digest),
    .digest_valid (digest_valid),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] ABC_D =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_D =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] EMPTY_D =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DBL_D =
    256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin,
                                            input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = hin[255:224]; b = hin[223:192]; c = hin[191:160]; d = hin[159:128];
    e = hin[127:96];  f = hin[95:64];   g = hin[63:32];   h = hin[31:0];
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160],
            d + hin[159:128], e + hin[127:96],  f + hin[95:64],
            g + hin[63:32],   h + hin[31:0]};
  endfunction

  // Behavioural core: reacts to state codes seen during each cycle
  logic [255:0] hm = '0;
  logic [511:0] blk = '0;
  logic [2:0]   prev_st = 3'd0;
  int elen = 0, rlen = 0, e_rec = 0, r_rec = 0;
  int req_cnt = 0, xfers = 0, dv_cnt = 0;

  always @(posedge clock) begin
    if (digest_valid) dv_cnt++;
    case (sha_state)
      3'd1: begin hm = IV; req_cnt = 0; xfers = 0; end
      3'd2: begin req_cnt++; if (chunk_valid) xfers++; end
      3'd3: begin
        if (!sha_flag) begin blk = sha_chunk; elen = 0; rlen = 0; end
        else elen++;
      end
      3'd4: rlen++;
      default: ;
    endcase
    if (prev_st == 3'd4 && sha_state != 3'd4) begin
      hm = compress(hm, blk);
      e_rec = elen;
      r_rec = rlen;
      sha_hash <= hm;
    end
    prev_st = sha_state;
  end

  int checks = 0;
  int errors = 0;
  int n = 0;
  int d0 = 0;
  logic stable;

  task automatic check(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    n++;
  endtask

  task automatic wait_dv(input int budget);
    while (!digest_valid && n < budget) step();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; chunk_in = '0;
    chunk_last = 1'b0; chunk_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_state", sha_state, 3'd0);
    check("rst_flag", sha_flag, 1'b0);
    check("rst_chunk", sha_chunk, 512'h0);
    check("rst_digest", digest, 256'h0);
    check("rst_dv", digest_valid, 1'b0);
    check("rst_ready", chunk_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(negedge clock);

`ifndef SHA_SEQ_DOUBLE_EN
    // single block "abc"
    chunk_in = ABC; chunk_last = 1'b1; chunk_valid = 1'b1;
    start = 1'b1; n = 0;
    step(); start = 1'b0;
    check("abc_init", sha_state, 3'd1);
    step();
    check("abc_req_ready", chunk_ready, 1'b1);
    step();
    check("abc_load", {sha_state, sha_flag}, {3'd3, 1'b0});
    check("abc_chunk", sha_chunk, ABC);
    step();
    check("abc_expand", {sha_state, sha_flag}, {3'd3, 1'b1});
    wait_dv(300);
    check("abc_dv_cycle", n, 118);
    check("abc_digest", digest, ABC_D);
    check("abc_busy", busy, 1'b0);
    check("abc_elen", e_rec, 48);
    check("abc_rlen", r_rec, 64);
    check("abc_xfers", xfers, 1);

    // two blocks with a 10-cycle valid stall before block 2
    step();
    chunk_in = B1; chunk_last = 1'b0; chunk_valid = 1'b1;
    start = 1'b1; n = 0;
    step(); start = 1'b0;
    step();
    step();
    chunk_in = B2; chunk_last = 1'b1; chunk_valid = 1'b0;
    while (sha_state != 3'd2 && n < 300) step();
    check("two_req2_cycle", n, 116);
    repeat (10) step();
    check("two_stall_req", sha_state, 3'd2);
    chunk_valid = 1'b1;
    wait_dv(400);
    check("two_dv_cycle", n, 242);
    check("two_digest", digest, TWO_D);
    check("two_req_cycles", req_cnt, 12);

    // start pulse in ROUND and valid held outside REQ
    step();
    chunk_in = ABC; chunk_last = 1'b1; chunk_valid = 1'b1;
    start = 1'b1; n = 0;
    step(); start = 1'b0;
    while (n < 60) step();
    start = 1'b1;
    step(); start = 1'b0;
    check("ign_round", sha_state, 3'd4);
    wait_dv(300);
    check("ign_dv_cycle", n, 118);
    check("ign_digest", digest, ABC_D);
    check("ign_xfers", xfers, 1);
    d0 = dv_cnt;
    repeat (10) step();
    check("ign_one_dv", dv_cnt, d0 + 1);
    check("ign_idle", busy, 1'b0);

    // reset in the middle of ROUND
    start = 1'b1; n = 0;
    step(); start = 1'b0;
    while (n < 81) step();
    reset = 1'b0;
    step();
    check("abort_state", {sha_state, sha_flag}, 4'd0);
    check("abort_chunk", sha_chunk, 512'h0);
    check("abort_digest", digest, 256'h0);
    check("abort_ctl", {digest_valid, chunk_ready, busy}, 3'b000);
    reset = 1'b1;
    d0 = dv_cnt;
    repeat (130) step();
    check("abort_no_dv", dv_cnt, d0);
    start = 1'b1; n = 0;
    step(); start = 1'b0;
    wait_dv(300);
    check("fresh_dv_cycle", n, 118);
    check("fresh_digest", digest, ABC_D);

    // back-to-back with start held high
    step();
    start = 1'b1; n = 0;
    wait_dv(300);
    check("b2b_dv1_cycle", n, 118);
    check("b2b_digest1", digest, ABC_D);
    step();
    check("b2b_init", sha_state, 3'd1);
    start = 1'b0;
    chunk_in = EMPTY;
    stable = 1'b1;
    while (!digest_valid && n < 400) begin
      if (digest !== ABC_D) stable = 1'b0;
      step();
    end
    check("b2b_hold", stable, 1'b1);
    check("b2b_dv2_cycle", n, 236);
    check("b2b_digest2", digest, EMPTY_D);
`else
    // double SHA-256 of "abc"
    chunk_in = ABC; chunk_last = 1'b1; chunk_valid = 1'b1;
    d0 = dv_cnt;
    start = 1'b1; n = 0;
    step(); start = 1'b0;
    while (n < 118 && !digest_valid) step();
    check("dbl_no_early_dv", dv_cnt, d0);
    check("dbl_init2", {sha_state, busy}, {3'd1, 1'b1});
    step();
    check("dbl_load2", {sha_state, sha_flag}, {3'd3, 1'b0});
    check("dbl_chunk2", sha_chunk, {ABC_D, 1'b1, 191'b0, 64'd256});
    wait_dv(400);
    check("dbl_dv_cycle", n, 234);
    check("dbl_digest", digest, DBL_D);
    repeat (10) step();
    check("dbl_one_dv", dv_cnt, d0 + 1);
    check("dbl_idle", busy, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_sequencer.md
# sha256_sequencer

Sequencing controller for the `SHA_256` compression core in the mining datapath. It accepts pre-padded 512-bit message blocks over a valid/ready handshake and drives the core's `state`, `flag` and `chunk` inputs through init, expand, round and output phases with exact cycle counts. It captures `HASH` into a registered digest with a one-cycle valid pulse. An optional build feature chains a second pass to produce the double SHA-256 used for block-header mining.

## Interface
Parameters:
- none. The block is fixed to the core's 3-bit state code and its 48-cycle expand / 64-cycle round schedule.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low.
- `start`  in  1  begin a new message; sampled only in IDLE.
- `chunk_in`  in  512  pre-padded message block, big-endian word order.
- `chunk_last`  in  1  qualifies `chunk_in` as the final block of the message.
- `chunk_valid`  in  1  `chunk_in` and `chunk_last` are valid.
- `chunk_ready`  out  1  high only in REQ; a block transfers when `chunk_valid` and `chunk_ready` are both high.
- `sha_state`  out  3  drives core `state`.
- `sha_flag`  out  1  drives core `flag`.
- `sha_chunk`  out  512  drives core `chunk`; a registered copy of the accepted block.
- `sha_hash`  in  256  from core `HASH`.
- `digest`  out  256  final digest; holds its value until the next capture.
- `digest_valid`  out  1  one-cycle pulse when `digest` updates.
- `busy`  out  1  low only in IDLE.

## Operation
- FSM states and their registered `sha_state`/`sha_flag` values:
  - IDLE: 0/0
  - INIT: 1/0
  - REQ: 2/0
  - LOAD: 3/0
  - EXPAND: 3/1
  - ROUND: 4/0
  - FINAL: 5/0
  - CAPTURE: 6/0
- State transitions:
  - IDLE: goes to INIT when `start`=1.
  - INIT: lasts 1 cycle, then goes to REQ.
  - REQ: waits for the handshake. On transfer it latches `chunk_in` into `sha_chunk` and `chunk_last` into `last_q`, then goes to LOAD.
  - LOAD: lasts 1 cycle, then goes to EXPAND.
  - EXPAND: lasts exactly 48 cycles, then goes to ROUND.
  - ROUND: lasts exactly 64 cycles. It then goes to FINAL if `last_q`=1, otherwise to REQ.
  - From ROUND back to REQ, INIT is not revisited, so the core's h0..h7 chain across blocks.
  - FINAL: lasts 1 cycle, during which the core latches HASH. It then goes to CAPTURE.
  - CAPTURE: `digest` takes `sha_hash` at the end of the cycle. `digest_valid`=1 the following cycle, and the FSM returns to IDLE.
- Phase counter: 6-bit, cleared on entry to EXPAND and on entry to ROUND.
  - EXPAND exits when the count reaches 47.
  - ROUND exits when the count reaches 63.
- Start handling:
  - `start` is ignored while `busy`=1.
  - `start` held high in IDLE begins exactly one message per IDLE visit.
- `chunk_valid` outside REQ is ignored; no block is accepted and nothing is queued.
- Messages must contain at least one block; padding is the caller's responsibility.

## Timing
- Reset (`reset`=0 at a clock edge):
  - FSM goes to IDLE; counter clears.
  - `sha_state`=0, `sha_flag`=0, `sha_chunk`=0, `digest`=0, `digest_valid`=0, `chunk_ready`=0, `busy`=0.
  - `last_q` and the pass bit clear.
  - Reset mid-message discards the message, and no `digest_valid` is produced for it.
- Per-block core occupancy after handshake: 113 cycles (LOAD 1 + EXPAND 48 + ROUND 64).
- Single-block latency, with `start` sampled at edge 0 and `chunk_valid` already high:
  - INIT in cycle 1, REQ in cycle 2 (transfer), LOAD in cycle 3.
  - EXPAND in cycles 4–51, ROUND in cycles 52–115.
  - FINAL in cycle 116, CAPTURE in cycle 117.
  - `digest_valid` in cycle 118; `busy` low from cycle 118.
- Each additional block adds 1 REQ cycle plus 113 cycles, plus any stall while `chunk_valid`=0.
- `digest_valid` and a new `start` may coincide in cycle 118. The start is accepted and `digest` holds until its next capture.

## Configuration
- `SHA_SEQ_DOUBLE_EN` defined: double SHA-256.
  - In CAPTURE of pass 1, the block loads `sha_chunk` = {`sha_hash`, 1'b1, 191'b0, 64'd256}, sets the pass bit, and goes to INIT then directly to LOAD, skipping REQ.
  - Pass 2 runs LOAD/EXPAND/ROUND/FINAL/CAPTURE as a single-block message.
  - Only the pass-2 CAPTURE updates `digest` and pulses `digest_valid`.
  - Single-block "abc" message: `digest_valid` in cycle 234.
- `SHA_SEQ_DOUBLE_EN` undefined: single SHA-256 only. The pass bit and internal chunk-build logic are not synthesized.

## Test plan
- "abc" single padded block (0x61626380…0018), build without the macro → `digest`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, `digest_valid` in cycle 118.
- 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" message as two blocks, with `chunk_valid` withheld 10 cycles before block 2 → `digest`=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1. While stalled, `sha_state`=2 for 10+1 cycles.
- "abc" block with `SHA_SEQ_DOUBLE_EN` defined → `digest`=4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358. Exactly one `digest_valid`, in cycle 234.
- `start` pulsed during ROUND and `chunk_valid` held high outside REQ → no extra transfer, `sha_state` sequence unchanged, one digest only.
- `reset`=0 asserted in ROUND cycle 30, then released and a fresh "abc" message run → all outputs at reset values one cycle later, no `digest_valid` for the aborted message, and the next message gives the correct digest.
- Back-to-back: `start` held high across the cycle-118 `digest_valid` → second message INIT in cycle 119, and the first digest stays stable until the second capture.
